// File: rtl/gfx256_wbs_ram.sv
// 256-bit Wishbone classic-cycle responder backed by an on-chip line RAM.
// Accepts writes and reads inside an address window; a display-refresh hold can stall acceptance.
module gfx256_wbs_ram #(
    parameter logic [3:0]  CID      = 4'd6,
    parameter logic [31:0] BASE_ADR = 32'h4000_0000,
    parameter int          DEPTH    = 1024,
    parameter int          RD_LAT   = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wbs_req_cyc,
    input  logic         wbs_req_stb,
    input  logic         wbs_req_we,
    input  logic [31:0]  wbs_req_sel,
    input  logic [31:0]  wbs_req_padr,
    input  logic [255:0] wbs_req_dat,
    input  logic [7:0]   wbs_req_tid,
    output logic         wbs_resp_ack,
    output logic         wbs_resp_err,
    output logic         wbs_resp_rty,
    output logic [3:0]   wbs_resp_cid,
    output logic [7:0]   wbs_resp_tid,
    output logic [255:0] wbs_resp_dat,
    input  logic         hold_i,
    output logic         busy_o
);

    localparam int DATA_W = 256;
    localparam int SEL_W  = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, RESP, DONE} state_t;

    state_t            state;
    logic              cnt;
    logic [7:0]        tid_q;
    logic              hit;
    logic              err_cond;
    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] rd_dat_p1;
    logic [DATA_W-1:0] rd_dat_p2;
    logic [DATA_W-1:0] rd_line;
    logic              unused_lsb;

    assign hit        = (wbs_req_padr[31:5+AW] == BASE_ADR[31:5+AW]);
    assign idx        = wbs_req_padr[5+AW-1:5];
    assign err_cond   = !hit || (wbs_req_sel == '0);
    assign accept     = (state == IDLE) && wbs_req_cyc && wbs_req_stb && !hold_i;
    assign wr_en      = accept && wbs_req_we && !err_cond;
    assign rd_en      = accept && !wbs_req_we && !err_cond;
    assign unused_lsb = ^wbs_req_padr[4:0];

    // Line select happens at acceptance; the optional second register stage
    // only exists to relax the RAM output path when RD_LAT is 2.
    assign rd_line      = (RD_LAT == 2) ? rd_dat_p2 : rd_dat_p1;
    assign wbs_resp_rty = 1'b0;
    assign busy_o       = (state != IDLE);

    // Stage p0 -> p1: RAM access (write lanes or line read)
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (wbs_req_sel[i]) begin
                    ram[idx][8*i +: 8] <= wbs_req_dat[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_dat_p1 <= ram[idx];
        end
        // Stage p1 -> p2: output register for the two-cycle read
        rd_dat_p2 <= rd_dat_p1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= 1'b0;
            tid_q        <= '0;
            wbs_resp_ack <= 1'b0;
            wbs_resp_err <= 1'b0;
            wbs_resp_cid <= '0;
            wbs_resp_tid <= '0;
            wbs_resp_dat <= '0;
        end else begin
            wbs_resp_ack <= 1'b0;
            wbs_resp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tid_q <= wbs_req_tid;
                        if (err_cond) begin
                            state        <= RESP;
                            wbs_resp_err <= 1'b1;
                            wbs_resp_dat <= '0;
                            wbs_resp_cid <= CID;
                            wbs_resp_tid <= wbs_req_tid;
                        end else if (wbs_req_we) begin
                            state        <= RESP;
                            wbs_resp_ack <= 1'b1;
                            wbs_resp_cid <= CID;
                            wbs_resp_tid <= wbs_req_tid;
                        end else begin
                            state <= RD;
                            cnt   <= 1'(RD_LAT - 1);
                        end
                    end
                end
                RD: begin
                    // Initiator abandoning the cycle beats a pending completion.
                    if (!wbs_req_cyc) begin
                        state <= IDLE;
                    end else if (cnt == 1'b0) begin
                        state        <= RESP;
                        wbs_resp_ack <= 1'b1;
                        wbs_resp_dat <= rd_line;
                        wbs_resp_cid <= CID;
                        wbs_resp_tid <= tid_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx256_wbs_ram.sv
// Self-checking bench for gfx256_wbs_ram: transaction-level memory model plus a per-cycle output checker.
module tb_gfx256_wbs_ram;

    localparam int          DEPTH  = 16;
    localparam int          RD_LAT = 2;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [3:0]  CID    = 4'd6;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0]  sel = '0, padr = '0;
    logic [255:0] wdat = '0;
    logic [7:0]   tid = '0;
    logic         hold_i = 1'b0;
    logic         ack, err, rty, busy;
    logic [3:0]   rcid;
    logic [7:0]   rtid;
    logic [255:0] rdat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    // Expected-response schedule, written by the driver, read by the checker
    int           exp_r = -1, busy_from = -1, busy_to = -1;
    logic         exp_ack = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
    logic [255:0] exp_dat = '0;
    logic [7:0]   exp_tid = '0;
    logic [255:0] model_dat = '0;
    logic [255:0] mem [DEPTH];

    localparam logic [255:0] PAT = 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF;

    gfx256_wbs_ram #(.CID(CID), .BASE_ADR(BASE), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wbs_req_cyc(cyc), .wbs_req_stb(stb), .wbs_req_we(we), .wbs_req_sel(sel),
        .wbs_req_padr(padr), .wbs_req_dat(wdat), .wbs_req_tid(tid),
        .wbs_resp_ack(ack), .wbs_resp_err(err), .wbs_resp_rty(rty),
        .wbs_resp_cid(rcid), .wbs_resp_tid(rtid), .wbs_resp_dat(rdat),
        .hold_i(hold_i), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc_cnt);
        end
    endtask

    always @(negedge clk) begin
        bit at_r;
        if (!rst_i) begin
            model_dat = '0;
            chk("reset ack", 256'(ack), 256'(0));
            chk("reset err", 256'(err), 256'(0));
            chk("reset busy", 256'(busy), 256'(0));
            chk("reset dat", rdat, '0);
        end else begin
            at_r = (cyc_cnt == exp_r);
            if (at_r && exp_err) model_dat = '0;
            else if (at_r && exp_ack && !exp_we) model_dat = exp_dat;
            chk("ack", 256'(ack), 256'(at_r && exp_ack));
            chk("err", 256'(err), 256'(at_r && exp_err));
            chk("rty", 256'(rty), 256'(0));
            chk("dat", rdat, model_dat);
            chk("busy", 256'(busy), 256'((cyc_cnt >= busy_from) && (cyc_cnt <= busy_to)));
            if (at_r) begin
                chk("tid", 256'(rtid), 256'(exp_tid));
                chk("cid", 256'(rcid), 256'(CID));
            end
        end
    end

    // abort_mode: 0 none, 1 drop cyc while reading, 2 reset while reading
    task automatic do_txn(input logic t_we, input logic [31:0] t_padr, input logic [31:0] t_sel,
                          input logic [255:0] t_dat, input logic [7:0] t_tid, input int hold,
                          input bit guard, input int abort_mode,
                          output logic o_ack, output logic o_err, output logic [255:0] o_dat,
                          output logic [7:0] o_tid);
        int  c, a, r, idx;
        bit  hit, is_err, aborted;
        @(negedge clk);
        c = cyc_cnt;
        cyc = 1'b1; stb = 1'b1; we = t_we; sel = t_sel; padr = t_padr; wdat = t_dat; tid = t_tid;
        hold_i = (hold > 0);
        hit = (t_padr >= BASE) && (t_padr < BASE + 32'(DEPTH * 32));
        idx = hit ? int'((t_padr - BASE) / 32) : 0;
        is_err = !hit || (t_sel == 0);
        a = c + hold;
        aborted = (abort_mode != 0) && !t_we && !is_err;
        exp_tid = t_tid; exp_we = t_we; exp_ack = !is_err; exp_err = is_err;
        if (is_err) begin
            r = a + 1;
        end else if (t_we) begin
            r = a + 1;
            for (int i = 0; i < 32; i++) if (t_sel[i]) mem[idx][8*i +: 8] = t_dat[8*i +: 8];
        end else begin
            r = a + RD_LAT + 1;
            exp_dat = mem[idx];
        end
        exp_r = aborted ? -1 : r;
        busy_from = a + 1;
        busy_to = aborted ? a + 1 : r + 1;
        o_ack = 1'b0; o_err = 1'b0; o_dat = '0; o_tid = '0;
        repeat (hold) @(negedge clk);
        hold_i = 1'b0;
        if (aborted && abort_mode == 1) begin
            @(negedge clk);
            cyc = 1'b0; stb = 1'b0;
            return;
        end
        if (aborted) begin
            @(posedge clk);
            @(posedge clk);
            #3 rst_i = 1'b0;
            #1;
            chk("async reset busy", 256'(busy), 256'(0));
            chk("async reset ack", 256'(ack), 256'(0));
            cyc = 1'b0; stb = 1'b0;
            busy_to = -1;
            repeat (2) @(negedge clk);
            rst_i = 1'b1;
            return;
        end
        while (cyc_cnt < r) begin
            @(negedge clk);
            if (cyc_cnt < r) hold_i = 1'($urandom % 2);
        end
        o_ack = ack; o_err = err; o_dat = rdat; o_tid = rtid;
        hold_i = 1'b0;
        if (guard) repeat (2) @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        if (!guard) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         a_, e_;
        logic [255:0] d_;
        logic [7:0]   t_;
        logic [255:0] rnd;
        logic [31:0]  ra, rs;
        #1 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 8; k++) rnd[32*k +: 32] = $urandom;
            do_txn(1'b1, BASE + 32'(i * 32), 32'hFFFF_FFFF, rnd, 8'(i), 0, 1'b0, 0, a_, e_, d_, t_);
        end

        do_txn(1'b1, 32'h4000_0040, 32'hFFFF_FFFF, PAT, 8'h51, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("full write ack", 256'(a_), 256'(1));
        chk("full write tid", 256'(t_), 256'(8'h51));
        do_txn(1'b0, 32'h4000_0040, 32'hFFFF_FFFF, '0, 8'h52, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("full read ack", 256'(a_), 256'(1));
        chk("full read dat", d_, PAT);

        do_txn(1'b1, 32'h4000_00A0, 32'hFFFF_FFFF, '0, 8'h10, 0, 1'b0, 0, a_, e_, d_, t_);
        do_txn(1'b1, 32'h4000_00A0, 32'h0000_0003, 256'hBEEF, 8'h11, 0, 1'b0, 0, a_, e_, d_, t_);
        do_txn(1'b0, 32'h4000_00A0, 32'hFFFF_FFFF, '0, 8'h12, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("byte lane readback", d_, 256'hBEEF);

        do_txn(1'b0, 32'h3FFF_FFE0, 32'hFFFF_FFFF, '0, 8'h20, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("window miss err", 256'(e_), 256'(1));
        chk("window miss ack", 256'(a_), 256'(0));
        chk("window miss dat", d_, '0);
        do_txn(1'b1, 32'h4000_00A0, 32'h0, {256{1'b1}}, 8'h21, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("sel zero err", 256'(e_), 256'(1));
        do_txn(1'b0, 32'h4000_00A0, 32'hFFFF_FFFF, '0, 8'h22, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("sel zero ram untouched", d_, 256'hBEEF);

        do_txn(1'b0, 32'h4000_0040, 32'hFFFF_FFFF, '0, 8'h30, 5, 1'b0, 0, a_, e_, d_, t_);
        chk("hold read dat", d_, PAT);

        do_txn(1'b0, 32'h4000_0040, 32'hFFFF_FFFF, '0, 8'h40, 0, 1'b0, 1, a_, e_, d_, t_);
        do_txn(1'b0, 32'h4000_00A0, 32'hFFFF_FFFF, '0, 8'h41, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("after abort dat", d_, 256'hBEEF);
        chk("after abort tid", 256'(t_), 256'(8'h41));

        do_txn(1'b1, 32'h4000_0060, 32'hFFFF_FFFF, PAT, 8'h42, 0, 1'b1, 0, a_, e_, d_, t_);
        chk("guard write ack", 256'(a_), 256'(1));

        do_txn(1'b0, 32'h4000_0040, 32'hFFFF_FFFF, '0, 8'h50, 0, 1'b0, 2, a_, e_, d_, t_);
        do_txn(1'b0, 32'h4000_0000, 32'hFFFF_FFFF, '0, 8'h53, 0, 1'b0, 0, a_, e_, d_, t_);
        chk("post reset read ack", 256'(a_), 256'(1));

        for (int n = 0; n < 300; n++) begin
            bit rwe;
            int hsel;
            rwe = 1'($urandom % 2);
            for (int k = 0; k < 8; k++) rnd[32*k +: 32] = $urandom;
            hsel = int'($urandom % 8);
            if (hsel == 0) ra = $urandom;
            else if (hsel == 1) ra = ($urandom % 2 == 0) ? BASE - 32'(32 * ($urandom % 4 + 1))
                                                          : BASE + 32'(DEPTH * 32) + 32'($urandom % 64);
            else ra = BASE + 32'(32 * ($urandom % DEPTH)) + 32'($urandom % 32);
            hsel = int'($urandom % 8);
            rs = (hsel == 0) ? 32'h0 : (hsel == 1) ? 32'hFFFF_FFFF : $urandom;
            do_txn(rwe, ra, rs, rnd, 8'($urandom),
                   ($urandom % 4 == 0) ? int'($urandom % 3) + 1 : 0,
                   ($urandom % 4 == 0), (!rwe && $urandom % 8 == 0) ? 1 : 0,
                   a_, e_, d_, t_);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gfx256_wbs_ram.md
Name: gfx256_wbs_ram

Overview:
- 256-bit Wishbone responder: terminates classic-cycle requests from the gfx256 texture/pixel masters on a local on-chip line RAM (texture/pattern store).
- Sits on the graphics-local bus opposite `gfx256_wbm_rw`-style initiators.
- Decodes an address window, performs byte-lane writes or pipelined reads, and returns ack/err with the initiator's tid echoed.
- Also arbitrates against a display-refresh hold input.

Parameters:
- CID, 4'd6, core id driven on response cid.
- BASE_ADR, 32'h4000_0000, window base; must be aligned to window size.
- DEPTH, 1024, number of 256-bit lines (power of two, 16..65536); AW = $clog2(DEPTH).
- RD_LAT, 2, RAM read latency in cycles, legal values 1 or 2 (2 adds output register).

Ports:
- clk_i  input  1  master clock.
- rst_i  input  1  asynchronous reset, active-low: asserted when 0, synchronous release.
- wbs_req  input  wb_cmd_request256_t  request from initiator (cyc, stb, we, sel, padr, dat, tid used; other fields ignored).
- wbs_resp  output  wb_cmd_response256_t  response: ack, err, rty, cid, tid, dat driven; all other fields 0.
- hold_i  input  1  display refresh owns RAM this cycle; new requests are not accepted.
- busy_o  output  1  transaction in progress (state != IDLE).

Behaviour:
- Reset (rst_i=0, async): state=IDLE, wbs_resp all zero, busy_o=0. RAM contents are not reset.
- Decode:
  - hit = padr[31:5+AW] == BASE_ADR[31:5+AW].
  - line index = padr[5+AW-1:5].
  - padr[4:0] ignored.
  - Error condition = !hit | (sel==0).
- States: IDLE, RD, RESP, DONE.
- IDLE:
  - If cyc&stb&!hold_i, accept and latch tid and index.
  - Error condition -> RESP with err=1, ack=0, dat=0. RAM untouched.
  - Write -> for each sel[i]=1, RAM[index][8i+7:8i] <= dat[8i+7:8i] this edge; -> RESP with ack=1.
  - Read -> issue RAM read; -> RD with latency counter = RD_LAT-1.
  - hold_i=1 with pending request: stay IDLE and do not sample (request held by initiator).
- RD:
  - Counter decrements each cycle.
  - At 0 -> RESP with ack=1, dat = RAM line.
  - Read data reflects all writes completed before acceptance.
- RESP:
  - Response fields registered. ack or err is high for exactly one cycle. tid echoes the latched tid; cid=CID; rty=0 always.
  - Next -> DONE; response cleared.
- DONE:
  - One-cycle guard; stb sampled here belongs to the just-completed cycle and is ignored.
  - -> IDLE.
- Latency, request-visible to ack-visible:
  - write/err: 1 cycle.
  - read: RD_LAT+1 cycles.
  - Back-to-back minimum spacing: 3 cycles per write.
- Abort: if cyc=0 while in RD -> IDLE immediately, no ack. A write already performed is not undone.
- dat holds the last read value between responses; on err, dat is 0.
- hold_i is ignored once a transaction is accepted.
- busy_o = (state != IDLE), combinational from state.
- Reset mid-transaction: outputs zero asynchronously; a pending ack is lost.

Test Plan:
- Reset: rst_i=0 mid-RD -> wbs_resp.ack=0, busy_o=0 same cycle; after release, read line 0 responds normally.
- Full write/read: write padr=32'h4000_0040 sel=all-ones dat=256'h0123..EF, tid=8'h51 -> ack 1 cycle later, tid=8'h51. Read same padr -> ack at RD_LAT+1 cycles, dat=256'h0123..EF.
- Byte lanes: line preloaded 0, write sel=32'h0000_0003 dat[15:0]=16'hBEEF -> readback 256'h...0000BEEF, other bytes 0.
- Out-of-window: read padr=32'h3FFF_FFE0 -> err=1 for one cycle, ack=0, dat=0. Also sel=0 write -> err=1, RAM unchanged.
- hold_i=1 for 5 cycles with pending read -> no response; ack at RD_LAT+1 cycles after hold_i drops.
- Abort and guard:
  - Drop cyc one cycle into RD with RD_LAT=2 -> no ack; next request serviced normally.
  - stb held high through DONE -> exactly one ack.
